// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array loader/drain controllers.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Write pointer must reach n itself to flag a full row.
  function automatic int unsigned ptr_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Index into 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_capture_buf.sv
// One row of the result buffer: N words written in arrival order, read by index.
module row_capture_buf
  import tpu_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned ACC_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr,
  input  logic [ACC_W-1:0]             data,
  input  logic [idx_w(N)-1:0]          rd_idx,
  output logic [ACC_W-1:0]             rd_word_c,
  output logic                         full_c,
  output logic                         ovf_c
);

  localparam int unsigned PTR_W = ptr_w(N);
  localparam int unsigned IDX_W = idx_w(N);

  logic [PTR_W-1:0] wp;
  logic [ACC_W-1:0] mem [N];

  assign full_c    = (wp == PTR_W'(N));
  assign ovf_c     = wr && full_c;
  assign rd_word_c = mem[rd_idx];

  // Writes beyond the Nth word are dropped; the top turns ovf_c into err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      for (int i = 0; i < int'(N); i++) mem[i] <= '0;
    end else if (clr) begin
      wp <= '0;
    end else if (wr && !full_c) begin
      mem[IDX_W'(wp)] <= data;
      wp              <= wp + PTR_W'(1);
    end
  end

endmodule

// File: rtl/output_control.sv
// Drain side of the systolic array: capture the skewed N x N result matrix,
// then stream it out row-major, LSB first, under a valid/ready handshake.
module output_control
  import tpu_pkg::*;
#(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned ACC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*ACC_W-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned BIT_W = idx_w(ACC_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ACC_W - 1);

  if (N < 2 || D_W == 0) begin : g_param_check
    $error("output_control: N must be >= 2 and D_W nonzero");
  end

  state_t           state;
  logic [IDX_W-1:0] row, col, nxt_row, nxt_col;
  logic [BIT_W-1:0] bit_cnt;
  logic [ACC_W-1:0] shreg;
  logic [ACC_W-1:0] rd_words [N];
  logic [N-1:0]     full, ovf;
  logic [ACC_W-1:0] load_word_c;
  logic             load_last_c, step_last_c;

  for (genvar r = 0; r < int'(N); r++) begin : g_row
    row_capture_buf #(.N(N), .ACC_W(ACC_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (start && (state == IDLE)),
      .wr        (in_valid[r] && (state == CAPTURE)),
      .data      (in_data[r*ACC_W +: ACC_W]),
      .rd_idx    (nxt_col),
      .rd_word_c (rd_words[r]),
      .full_c    (full[r]),
      .ovf_c     (ovf[r])
    );
  end

  // Address of the word to load next: word 0 when entering SHIFT, else row-major successor.
  always_comb begin
    nxt_row = '0;
    nxt_col = '0;
    if (state == SHIFT) begin
      nxt_row = row;
      nxt_col = col + IDX_W'(1);
      if (col == LAST_IDX) begin
        nxt_row = row + IDX_W'(1);
        nxt_col = '0;
      end
    end
  end

  assign load_word_c = rd_words[nxt_row];
  assign load_last_c = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX) && (ACC_W == 1);
  assign step_last_c = (row == LAST_IDX) && (col == LAST_IDX) && (bit_cnt == BIT_W'(ACC_W - 2));
  assign out_bit     = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (|ovf) err <= 1'b1;
          if (&full) begin
            state     <= SHIFT;
            shreg     <= load_word_c;
            row       <= '0;
            col       <= '0;
            bit_cnt   <= '0;
            out_valid <= 1'b1;
            out_last  <= load_last_c;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= DONE;
              shreg     <= '0;
              row       <= '0;
              col       <= '0;
              bit_cnt   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              row      <= nxt_row;
              col      <= nxt_col;
              shreg    <= load_word_c;
              out_last <= load_last_c;
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              shreg    <= shreg >> 1;
              out_last <= step_last_c;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_control.sv
// Self-checking bench for output_control: directed scenarios plus random trials
// compared against a queue-based model of the expected serial stream.
module tb_output_control;

  localparam int unsigned N     = 2;
  localparam int unsigned ACC_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N*ACC_W-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic               out_ready;
  logic               out_bit, out_valid, out_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] words [N][N+1];
  int               sk [N];
  int               nv [N];
  bit               exp_q [$];
  logic [ACC_W-1:0] got_words [$];

  always #5 clk = ~clk;

  output_control #(.D_W(8), .N(N), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: first N words of each row, row-major, LSB first.
  task automatic build_model();
    logic [ACC_W-1:0] w;
    exp_q.delete();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        w = words[r][c];
        for (int b = 0; b < int'(ACC_W); b++) exp_q.push_back(w[b]);
      end
  endtask

  // Pulse start, then drive each row's valids starting at its own skew.
  task automatic capture();
    int  c_last;
    bit  exp_err;
    logic v;
    c_last  = 0;
    exp_err = 1'b0;
    for (int r = 0; r < int'(N); r++) begin
      if (sk[r] + int'(N) - 1 > c_last) c_last = sk[r] + int'(N) - 1;
    end
    for (int r = 0; r < int'(N); r++)
      if (nv[r] > int'(N) && sk[r] + int'(N) <= c_last + 1) exp_err = 1'b1;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared_by_start", err, 0);
    for (int c = 0; c <= c_last + 1; c++) begin
      for (int r = 0; r < int'(N); r++) begin
        v = (c >= sk[r]) && (c < sk[r] + nv[r]);
        in_valid[r] = v;
        in_data[r*ACC_W +: ACC_W] = v ? words[r][c - sk[r]] : ACC_W'($urandom);
      end
      @(negedge clk);
      if (c == c_last) check("no_shift_before_full", out_valid, 0);
    end
    in_valid = '0;
    check("err_after_capture", err, exp_err);
  endtask

  // Drain the stream; mode 0 ready high, 1 toggling, 2 random. abort_at >= 0 resets mid-stream.
  task automatic drain(input int mode, input int abort_at, input bit noise);
    int   idx, cyc, total;
    logic rdy;
    logic [ACC_W-1:0] acc;
    idx   = 0;
    cyc   = 0;
    acc   = '0;
    total = exp_q.size();
    got_words.delete();
    check("out_valid_latency", out_valid, 1);
    while (idx < total && cyc < 2000) begin
      check("out_valid_held", out_valid, 1);
      check("out_bit", out_bit, exp_q[idx]);
      check("out_last", out_last, (idx == total - 1));
      if (idx == abort_at) begin
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {out_bit, out_valid, out_last, busy, done, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = '0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, out_valid}, 0);
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
      out_ready = rdy;
      if (noise) begin
        in_valid = N'($urandom);
        in_data  = (N*ACC_W)'($urandom);
        start    = (cyc == 5);
      end
      if (rdy) begin
        acc[idx % int'(ACC_W)] = out_bit;
        idx++;
        if (idx % int'(ACC_W) == 0) got_words.push_back(acc);
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = '0;
    start     = 1'b0;
    check("drain_within_budget", idx, total);
    check("done_pulse", done, 1);
    check("out_valid_after_done", out_valid, 0);
    check("busy_after_done", busy, 0);
    if (mode == 0) check("done_latency", cyc, total);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic set_row(input int r, input logic [ACC_W-1:0] w0, input logic [ACC_W-1:0] w1);
    words[r][0] = w0;
    words[r][1] = w1;
    words[r][2] = 16'hDEAD;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #12;
    check("reset_outputs", {out_bit, out_valid, out_last, busy, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // in_valid while IDLE is ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = '1;
      in_data  = (N*ACC_W)'($urandom);
      @(negedge clk);
      check("idle_invalid_ignored", {busy, out_valid, err}, 0);
    end
    in_valid = '0;

    // aligned capture
    set_row(0, 16'h0001, 16'h0002);
    set_row(1, 16'h0003, 16'h0004);
    sk[0] = 0; sk[1] = 0; nv[0] = 2; nv[1] = 2;
    capture();
    drain(0, -1, 1'b0);
    check("aligned_words", {got_words[0], got_words[1], got_words[2], got_words[3]},
          64'h0001_0002_0003_0004);

    // skewed capture
    sk[1] = 1;
    capture();
    drain(0, -1, 1'b0);

    // backpressure, with start and in_valid noise during SHIFT
    set_row(0, 16'hA5A5, 16'hFFFF);
    set_row(1, 16'h0000, 16'h8001);
    sk[1] = 0;
    capture();
    drain(1, -1, 1'b1);
    check("bp_words", {got_words[0], got_words[1], got_words[2], got_words[3]},
          64'hA5A5_FFFF_0000_8001);

    // overflow: third valid on row 0 while row 1 still filling
    set_row(0, 16'h1234, 16'h5678);
    set_row(1, 16'h9ABC, 16'h0F0F);
    sk[0] = 0; sk[1] = 1; nv[0] = 3; nv[1] = 2;
    capture();
    drain(0, -1, 1'b0);
    foreach (got_words[i]) check("no_dead_word", (got_words[i] == 16'hDEAD), 0);
    check("err_sticky_after_done", err, 1);

    // async reset at bit 20, then a fresh capture (start also clears err)
    nv[0] = 2;
    for (int r = 0; r < int'(N); r++) set_row(r, ACC_W'($urandom), ACC_W'($urandom));
    capture();
    drain(0, 20, 1'b0);
    check("err_cleared_by_reset", err, 0);
    for (int r = 0; r < int'(N); r++) set_row(r, ACC_W'($urandom), ACC_W'($urandom));
    sk[0] = 0; sk[1] = 0;
    capture();
    drain(2, -1, 1'b0);

    // random trials
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < int'(N); r++) begin
        set_row(r, ACC_W'($urandom), ACC_W'($urandom));
        sk[r] = int'($urandom_range(0, 3));
        nv[r] = 2;
      end
      capture();
      drain(int'($urandom_range(0, 2)), -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
